// File: rtl/vga_tile_if.sv
// vga_tile_if: scan request/pixel and CPU cell-access signals of the tile source
interface vga_tile_if;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic [15:0] dout;
    logic        cell_we;
    logic [8:0]  cell_addr;
    logic [3:0]  cell_din;
    logic [3:0]  cell_dout;
    logic [8:0]  cursor_addr;
    logic        clear_req;
    logic        busy;
    modport master (
        output row, col, rdn, cell_we, cell_addr, cell_din, cursor_addr, clear_req,
        input  dout, cell_dout, busy
    );
    modport slave (
        input  row, col, rdn, cell_we, cell_addr, cell_din, cursor_addr, clear_req,
        output dout, cell_dout, busy
    );
endinterface

// File: rtl/vga_tile_source.sv
// vga_tile_source: renders a 20x15 minesweeper board from a cell-code RAM as VGA pixels
module vga_tile_source #(
    parameter int         CELLS       = 300,
    parameter int         BLINK_BIT   = 4,
    parameter logic [3:0] HIDDEN_CODE = 4'd9
) (
    input logic       clk,
    input logic       rst_n,
    vga_tile_if.slave bus
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t      state;
    logic [8:0]  clr_addr;
    logic        busy_q;
    logic [4:0]  frame_cnt;
    logic [15:0] dout_q;
    logic [3:0]  cell_dout_q;
    logic [3:0]  mem [CELLS];
    logic [8:0]  idx;
    logic [4:0]  x, y;
    logic [3:0]  code;
    logic        visible, inner, edge_px, on_cursor, frame_end, cpu_wr;
    logic [11:0] num_rgb, rgb;
    assign bus.dout      = dout_q;
    assign bus.cell_dout = cell_dout_q;
    assign bus.busy      = busy_q;
    assign x         = bus.col[4:0];
    assign y         = bus.row[4:0];
    assign idx       = 9'(bus.row[8:5]) * 9'd20 + 9'(bus.col[9:5]);
    assign code      = idx < 9'(CELLS) ? mem[idx] : 4'd0;
    assign visible   = !bus.rdn && bus.row < 9'd480 && bus.col < 10'd640;
    assign inner     = x >= 5'd12 && x <= 5'd19 && y >= 5'd12 && y <= 5'd19;
    assign edge_px   = x == 5'd1 || x == 5'd31 || y == 5'd1 || y == 5'd31;
    assign on_cursor = bus.cursor_addr == idx && bus.cursor_addr < 9'(CELLS) && frame_cnt[BLINK_BIT] && edge_px;
    assign frame_end = !bus.rdn && bus.row == 9'd479 && bus.col == 10'd639;
    assign cpu_wr    = state == IDLE && bus.cell_we && bus.cell_addr < 9'(CELLS);
    // number palette for revealed cells showing a neighbour count
    always_comb begin
        num_rgb = 12'hCCC;
        case (code)
            4'd1: num_rgb = 12'h00F;
            4'd2: num_rgb = 12'h080;
            4'd3: num_rgb = 12'hF00;
            4'd4: num_rgb = 12'h008;
            4'd5: num_rgb = 12'h800;
            4'd6: num_rgb = 12'h088;
            4'd7: num_rgb = 12'h000;
            4'd8: num_rgb = 12'h888;
            default: num_rgb = 12'hCCC;
        endcase
    end
    // colour priority: cursor outline, grid lines, then the cell's own artwork
    always_comb begin
        rgb = on_cursor ? 12'hFF0 :
              (x == 5'd0 || y == 5'd0) ? 12'h444 :
              code == 4'd0 ? 12'hCCC :
              code <= 4'd8 ? (inner ? num_rgb : 12'hCCC) :
              code == 4'd9 ? 12'h999 :
              code == 4'd10 ? (inner ? 12'hF80 : 12'h999) :
              code == 4'd11 ? (inner ? 12'h000 : 12'hF00) : 12'hF0F;
    end
    // cell RAM: the clear sweep owns the write port, otherwise the CPU does
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clr_addr] <= HIDDEN_CODE;
        else if (cpu_wr) mem[bus.cell_addr] <= bus.cell_din;
    end
    // clear engine: sweeps every cell to the hidden code, then waits for a re-clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr == 9'(CELLS - 1) ? 9'd0 : clr_addr + 9'd1;
            state    <= clr_addr == 9'(CELLS - 1) ? IDLE : CLEAR;
            busy_q   <= clr_addr != 9'(CELLS - 1);
        end else if (bus.clear_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end
    end
    // registered pixel, readback and blink frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            cell_dout_q <= '0;
            frame_cnt   <= '0;
        end else begin
            dout_q      <= visible ? {4'h0, rgb} : 16'h0;
            cell_dout_q <= bus.cell_addr < 9'(CELLS) ? mem[bus.cell_addr] : 4'd0;
            frame_cnt   <= frame_end ? frame_cnt + 5'd1 : frame_cnt;
        end
    end
endmodule

// File: tb/tb_vga_tile_source.sv
// tb_vga_tile_source: directed and random checks of the tile source against a board model
module tb_vga_tile_source;
    logic clk = 0;
    logic rst_n = 0;
    vga_tile_if bus ();
    int n_chk = 0;
    int n_pass = 0;
    int m_mem [300];
    int m_clr, m_frame;
    bit m_busy;
    int hi;
    logic [11:0] pal [9] = '{12'hCCC, 12'h00F, 12'h080, 12'hF00, 12'h008, 12'h800, 12'h088, 12'h000, 12'h888};

    vga_tile_source dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_pix(int r, int c, bit rd, int cur);
        int idx, x, y, code;
        bit inner;
        logic [11:0] rgb;
        if (rd || r >= 480 || c >= 640) return 16'h0;
        idx = (r / 32) * 20 + c / 32;
        x = c % 32;
        y = r % 32;
        code = m_mem[idx];
        inner = x >= 12 && x <= 19 && y >= 12 && y <= 19;
        if (idx == cur && (m_frame / 16) % 2 == 1 && (x == 1 || x == 31 || y == 1 || y == 31)) rgb = 12'hFF0;
        else if (x == 0 || y == 0) rgb = 12'h444;
        else if (code <= 8) rgb = inner ? pal[code] : 12'hCCC;
        else if (code == 9) rgb = 12'h999;
        else if (code == 10) rgb = inner ? 12'hF80 : 12'h999;
        else if (code == 11) rgb = inner ? 12'h000 : 12'hF00;
        else rgb = 12'hF0F;
        return {4'h0, rgb};
    endfunction

    task automatic model_reset();
        m_busy = 1;
        m_clr = 0;
        m_frame = 0;
    endtask

    task automatic drive(int r, int c, bit rd, bit we, int a, int d, bit clr);
        bus.row = 9'(r);
        bus.col = 10'(c);
        bus.rdn = rd;
        bus.cell_we = we;
        bus.cell_addr = 9'(a);
        bus.cell_din = 4'(d);
        bus.clear_req = clr;
    endtask

    task automatic tick(input string tag);
        logic [15:0] ed;
        logic [3:0] ec;
        int a;
        a = int'(bus.cell_addr);
        ed = ref_pix(int'(bus.row), int'(bus.col), bus.rdn, int'(bus.cursor_addr));
        ec = a < 300 ? 4'(m_mem[a]) : 4'd0;
        if (m_busy) begin
            m_mem[m_clr] = 9;
            m_clr++;
            if (m_clr == 300) m_busy = 0;
        end else begin
            if (bus.cell_we && a < 300) m_mem[a] = int'(bus.cell_din);
            if (bus.clear_req) begin
                m_busy = 1;
                m_clr = 0;
            end
        end
        if (!bus.rdn && bus.row == 479 && bus.col == 639) m_frame = (m_frame + 1) % 32;
        @(posedge clk);
        #1;
        check({tag, "_dout"}, 32'(bus.dout), 32'(ed));
        check({tag, "_cell_dout"}, 32'(bus.cell_dout), 32'(ec));
        check({tag, "_busy"}, 32'(bus.busy), 32'(m_busy));
    endtask

    initial begin
        int r, c, a;
        bit rd;
        drive(0, 0, 1, 0, 300, 0, 0);
        bus.cursor_addr = 9'd300;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_cell_dout", 32'(bus.cell_dout), 0);
        check("rst_busy", 32'(bus.busy), 1);
        rst_n = 1;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick("init");
            if (bus.busy) hi++;
        end
        check("init_busy_cycles", 32'(hi), 299);
        check("init_busy_fall", 32'(bus.busy), 0);
        drive(0, 0, 1, 0, 0, 0, 0);     tick("rb0");   check("rb_addr0", 32'(bus.cell_dout), 9);
        drive(0, 0, 1, 0, 150, 0, 0);   tick("rb150"); check("rb_addr150", 32'(bus.cell_dout), 9);
        drive(0, 0, 1, 0, 299, 0, 0);   tick("rb299"); check("rb_addr299", 32'(bus.cell_dout), 9);
        drive(0, 0, 1, 0, 300, 0, 0);   tick("rb300"); check("rb_addr300", 32'(bus.cell_dout), 0);
        drive(0, 0, 1, 1, 21, 3, 0);    tick("wr21");
        drive(40, 48, 0, 0, 300, 0, 0); tick("num_out"); check("num_outer", 32'(bus.dout), 32'h0CCC);
        drive(48, 48, 0, 0, 300, 0, 0); tick("num_in");  check("num_inner", 32'(bus.dout), 32'h0F00);
        drive(32, 40, 0, 0, 300, 0, 0); tick("grid");    check("grid_line", 32'(bus.dout), 32'h0444);
        drive(100, 100, 1, 0, 300, 0, 0); tick("blank"); check("rdn_blank", 32'(bus.dout), 0);
        drive(480, 100, 0, 0, 300, 0, 0); tick("offscr"); check("row_480", 32'(bus.dout), 0);
        bus.cursor_addr = 9'd0;
        for (int i = 0; i < 16; i++) begin
            drive(479, 639, 0, 0, 300, 0, 0);
            tick("frm");
        end
        drive(1, 5, 0, 0, 300, 0, 0); tick("cur_on");  check("cursor_on", 32'(bus.dout), 32'h0FF0);
        for (int i = 0; i < 16; i++) begin
            drive(479, 639, 0, 0, 300, 0, 0);
            tick("frm");
        end
        drive(1, 5, 0, 0, 300, 0, 0); tick("cur_off"); check("cursor_off", 32'(bus.dout), 32'h0999);
        drive(0, 0, 1, 1, 5, 11, 0); tick("rbw");  check("rbw_old", 32'(bus.cell_dout), 9);
        drive(0, 0, 1, 0, 5, 0, 0);  tick("rbw2"); check("rbw_new", 32'(bus.cell_dout), 11);
        drive(0, 0, 1, 0, 5, 0, 1);  tick("clrq");
        hi = bus.busy ? 1 : 0;
        drive(0, 0, 1, 1, 5, 4, 0);
        for (int i = 0; i < 300; i++) begin
            tick("reclr");
            if (bus.busy) hi++;
        end
        check("reclr_busy_cycles", 32'(hi), 300);
        check("reclr_busy_fall", 32'(bus.busy), 0);
        drive(0, 0, 1, 0, 5, 0, 0); tick("c5"); check("cell5_cleared", 32'(bus.cell_dout), 9);
        drive(40, 48, 0, 0, 300, 0, 1); tick("clrq2");
        drive(40, 48, 0, 0, 300, 0, 0);
        for (int i = 0; i < 120; i++) tick("midclr");
        check("midclr_pixel", 32'(bus.dout), 32'h0999);
        #2;
        rst_n = 0;
        #1;
        check("midrst_dout", 32'(bus.dout), 0);
        check("midrst_busy", 32'(bus.busy), 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick("reinit");
            if (bus.busy) hi++;
        end
        check("reinit_busy_cycles", 32'(hi), 299);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 511);
            c = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) begin
                r = r % 480;
                c = c % 640;
            end
            if ($urandom_range(0, 7) == 0) begin
                r = 479;
                c = 639;
            end
            rd = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 3) == 0 && r < 480 && c < 640) bus.cursor_addr = 9'((r / 32) * 20 + c / 32);
            else if ($urandom_range(0, 49) == 0) bus.cursor_addr = 9'($urandom_range(0, 310));
            a = $urandom_range(0, 319);
            drive(r, c, rd, $urandom_range(0, 2) == 0, a, $urandom_range(0, 15), $urandom_range(0, 299) == 0);
            tick("rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_tile_source.md
Name: vga_tile_source

Overview:
- Pixel-source end of the VGA scan interface. Answers each row/col/rdn request with a registered 16-bit pixel word one clock later.
- Renders a 20x15 grid of 32x32-pixel minesweeper cells from an internal 300-entry cell-code RAM.
- The CPU side writes and reads back cell codes. A clear engine initialises the board, and a frame-synchronous blink drives the cursor highlight.

Parameters:
- CELLS, 300, number of cells (20 columns x 15 rows); fixed by the 640x480 geometry
- BLINK_BIT, 4, frame-counter bit that sets the cursor blink phase (toggles every 16 frames)
- HIDDEN_CODE, 9, cell code written by the clear engine

Ports:
- clk  in  1  system clock, also the pixel clock
- rst_n  in  1  asynchronous, active-low reset
- row  in  9  scan row request, 0..479 visible
- col  in  10  scan column request, 0..639 visible
- rdn  in  1  active-low read strobe; 1 = blanking
- dout  out  16  pixel word: [15:12]=0, [11:8]=R, [7:4]=G, [3:0]=B
- cell_we  in  1  CPU cell write enable
- cell_addr  in  9  CPU cell index, 0..299
- cell_din  in  4  CPU cell code to write
- cell_dout  out  4  registered readback of cell_addr
- cursor_addr  in  9  highlighted cell index
- clear_req  in  1  one-cycle request to re-clear the board
- busy  out  1  high while the clear engine runs

Behaviour:
- Reset (rst_n=0, async): dout=0, cell_dout=0, busy=1, state=CLEAR, clr_addr=0, frame_cnt=0. RAM contents are not reset; the clear engine initialises them.
- Cell index: idx = row[8:5]*20 + col[9:5]. Pixel offsets: x=col[4:0], y=row[4:0]. Cell RAM read is asynchronous; dout is registered, so latency is exactly 1 clock from the row/col/rdn sample.
- dout forced to 0 when rdn=1, row>=480 or col>=640.
- Colour priority, highest first:
  1. Cursor: idx==cursor_addr, cursor_addr<300, frame_cnt[BLINK_BIT]=1, and x or y is 1 or 31 -> 12'hFF0.
  2. Grid: x==0 or y==0 -> 12'h444.
  3. Cell code, with inner square = x and y both in 12..19:
     - 0: 12'hCCC.
     - 1..8: inner square in number colour, else 12'hCCC. Colours: 1=00F, 2=080, 3=F00, 4=008, 5=800, 6=088, 7=000, 8=888.
     - 9 (hidden): 12'h999.
     - 10 (flag): inner square 12'hF80, else 12'h999.
     - 11 (mine): inner square 12'h000, else 12'hF00.
     - 12..15: 12'hF0F.
- Frame counter: 5-bit, increments on the clock edge where rdn=0, row=479, col=639. Wraps 31->0.
- Clear FSM:
  - CLEAR: write HIDDEN_CODE to clr_addr every cycle, then increment. After writing 299, go to IDLE with busy=0 on the next edge. A full clear takes 300 cycles after reset release.
  - IDLE: clear_req=1 -> CLEAR with clr_addr=0; busy=1 from the next edge.
  - clear_req is ignored while in CLEAR; the sweep does not restart.
- CPU write (IDLE only): cell_we=1 and cell_addr<300 writes cell_din at the edge. cell_we is ignored in CLEAR, and addresses >=300 are ignored.
- Readback: cell_dout <= RAM[cell_addr] every cycle, or 0 if cell_addr>=300. Same-cycle write to the same address returns the old value (read-before-write). The video path likewise shows the old value in that cycle.
- Video reads continue during CLEAR and display current RAM contents.
- rst_n asserted mid-clear or mid-frame restarts CLEAR from address 0 and zeroes frame_cnt.

Test Plan:
- Release reset, wait 300 clocks -> busy falls exactly 300 cycles after release. Readback of addr 0, 150 and 299 returns 9. Readback of addr 300 returns 0.
- Write code 3 to cell 21, then scan row=40, col=48 (x=16,y=8) and row=48, col=48 (x=16,y=16) with rdn=0 -> dout=16'h0CCC then 16'h0F00, each 1 clock after the request.
- Scan row=32, col=40 (y=0), then rdn=1 at a visible pixel, then row=480 with rdn=0 -> dout=16'h0444, then 0, then 0.
- cursor_addr=0; drive 16 last-pixel events (rdn=0, row=479, col=639); then scan row=1, col=5 -> dout=16'h0FF0. After 16 more events the same pixel -> 16'h0999.
- In IDLE, write cell 5 = 11 with cell_addr=5 in the same cycle -> cell_dout shows 9 on that edge, 11 on the next. Pulse clear_req -> busy=1 for 300 cycles; a cell_we during that window has no effect; cell 5 reads 9 afterwards.
- Assert rst_n=0 at clr_addr=120 -> dout=0 and busy=1 immediately. After release, a full 300-cycle clear runs.
